// File: rtl/if_id_fifo.sv
// -----------------------------------------------------------------------------
// if_id_fifo: instruction buffer between fetch and decode.
//
// Holds up to DEPTH fetched {inst, addr} pairs in a circular FIFO and presents
// the head entry to decode. When empty, decode sees NOP_INST at address 0.
// A flush drops all buffered entries (pointers and count only).
//
// Parameters:
//   DEPTH     number of entries, power of two, 2..8
//   NOP_INST  word presented when nothing valid is held
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   inst_i, inst_addr_i      fetched instruction and its PC
//   valid_i / ready_o        fetch-side handshake
//   inst_o, inst_addr_o      head instruction and PC to decode
//   valid_o / ready_i        decode-side handshake
//   flush_i                  control-flow flush, discards all contents
//   level_o                  current occupancy, 0..DEPTH
//
// Optional feature macro: IF_ID_BYPASS_EN
//   When defined, an instruction offered to an empty buffer is forwarded
//   combinationally to decode; it is only written if decode stalls.
// -----------------------------------------------------------------------------
module if_id_fifo #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              inst_i,
  input  logic [31:0]              inst_addr_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [31:0]              inst_o,
  output logic [31:0]              inst_addr_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   addr_mem_q [DEPTH];

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic empty;
  logic full;
  logic bypass;
  logic bypass_take;
  logic push;
  logic pop;

  // Handshake and head presentation, derived from registered state
  // (plus the fetch inputs when bypass is compiled in).
  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(DEPTH));
    ready_o = ~full & ~rst;
    level_o = cnt_q;

    valid_o     = ~empty;
    inst_o      = empty ? NOP_INST : inst_mem_q[rp_q];
    inst_addr_o = empty ? 32'h0    : addr_mem_q[rp_q];

`ifdef IF_ID_BYPASS_EN
    bypass = empty & valid_i & ~flush_i & ~rst;
    if (bypass) begin
      valid_o     = 1'b1;
      inst_o      = inst_i;
      inst_addr_o = inst_addr_i;
    end
`else
    bypass = 1'b0;
`endif

    // A bypassed word consumed in the same cycle never touches storage.
    bypass_take = bypass & ready_i;

    push = valid_i & ready_o & ~flush_i;
    pop  = valid_o & ready_i;
  end

  // Pointer and occupancy next-state; flush wins over push and pop.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else if (!bypass_take) begin
      if (push) wp_d = wp_q + PW'(1);
      if (pop)  rp_d = rp_q + PW'(1);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is deliberately not cleared; only pointers and count are.
  always_ff @(posedge clk) begin
    if (push && !bypass_take) begin
      inst_mem_q[wp_q] <= inst_i;
      addr_mem_q[wp_q] <= inst_addr_i;
    end
  end

endmodule
